// File: rtl/regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// regfile_write_arbiter
//   Two-requester (ALU / load) writeback arbiter for a single-write-port regfile.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic [NUM_REGS-1:0]   pending
);

    localparam logic [ADDR_WIDTH-1:0] C_ZERO_ADDR = '0;

    logic                  r_alu_v;
    logic [ADDR_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_d;
    logic                  r_mem_v;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [DATA_WIDTH-1:0] r_mem_d;
    logic                  r_mem_older;   // 1: MEM entry is older than ALU entry
    logic                  r_last_mem;    // 1: most recent grant went to MEM

    logic w_gnt_alu;
    logic w_gnt_mem;
    logic w_alu_load;
    logic w_mem_load;

    // Grant is a function of slot state only, so ready never loops back to valid.
    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (r_alu_v && r_mem_v) begin
            if (r_alu_a == r_mem_a) begin
                w_gnt_mem = r_mem_older;
            end else begin
                w_gnt_mem = !r_last_mem;
            end
            w_gnt_alu = !w_gnt_mem;
        end else begin
            w_gnt_alu = r_alu_v;
            w_gnt_mem = r_mem_v;
        end
    end

    assign alu_ready = Reset_n && (!r_alu_v || w_gnt_alu);
    assign mem_ready = Reset_n && (!r_mem_v || w_gnt_mem);

    // Writes to register 0 are accepted but dropped so r0 stays hard-zero.
    assign w_alu_load = alu_valid && alu_ready && (alu_addr != C_ZERO_ADDR);
    assign w_mem_load = mem_valid && mem_ready && (mem_addr != C_ZERO_ADDR);

    always_comb begin
        regWrite      = w_gnt_alu || w_gnt_mem;
        writeRegister = '0;
        writeData     = '0;
        if (w_gnt_alu) begin
            writeRegister = r_alu_a;
            writeData     = r_alu_d;
        end else if (w_gnt_mem) begin
            writeRegister = r_mem_a;
            writeData     = r_mem_d;
        end
    end

    always_comb begin
        pending = '0;
        if (r_alu_v) pending[r_alu_a] = 1'b1;
        if (r_mem_v) pending[r_mem_a] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_alu_v     <= 1'b0;
            r_alu_a     <= '0;
            r_alu_d     <= '0;
            r_mem_v     <= 1'b0;
            r_mem_a     <= '0;
            r_mem_d     <= '0;
            r_mem_older <= 1'b0;
            r_last_mem  <= 1'b1;
        end else begin
            if (w_alu_load) begin
                r_alu_v <= 1'b1;
                r_alu_a <= alu_addr;
                r_alu_d <= alu_data;
            end else if (w_gnt_alu) begin
                r_alu_v <= 1'b0;
            end

            if (w_mem_load) begin
                r_mem_v <= 1'b1;
                r_mem_a <= mem_addr;
                r_mem_d <= mem_data;
            end else if (w_gnt_mem) begin
                r_mem_v <= 1'b0;
            end

            // A new entry is younger only if the other slot survives this edge.
            if (w_alu_load && w_mem_load) begin
                r_mem_older <= 1'b0;
            end else if (w_alu_load) begin
                r_mem_older <= r_mem_v && !w_gnt_mem;
            end else if (w_mem_load) begin
                r_mem_older <= !(r_alu_v && !w_gnt_alu);
            end

            if (regWrite) begin
                r_last_mem <= w_gnt_mem;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed, table-driven bench with a behavioural register file model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic          regWrite;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic [NR-1:0] pending;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf [NR] = '{default: '0};

    regfile_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .pending       (pending)
    );

    always #5 Clk = ~Clk;

    // Register file model: outputs are stable from mid-cycle to the next rising edge.
    always @(negedge Clk) begin
        if (regWrite) rf[writeRegister] <= writeData;
    end

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          ear;
        logic          emr;
        logic          erw;
        logic [AW-1:0] ewr;
        logic [DW-1:0] ewd;
        logic [NR-1:0] epend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic av, input int aa, input int ad,
                       input logic mv, input int ma, input int md,
                       input logic ear, input logic emr, input logic erw,
                       input int ewr, input int ewd, input int epend);
        vec_t v;
        v.av = av;  v.aa = AW'(aa);  v.ad = DW'(ad);
        v.mv = mv;  v.ma = AW'(ma);  v.md = DW'(md);
        v.ear = ear; v.emr = emr; v.erw = erw;
        v.ewr = AW'(ewr); v.ewd = DW'(ewd); v.epend = NR'(epend);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
    endtask

    initial begin
        // Contention: ALU r3 <- 19..22, MEM r4 <- 7..10, alternating from ALU.
        add(1, 3, 19, 1, 4,  7,  1, 1, 0, 0,  0, 'h000);
        add(1, 3, 20, 1, 4,  8,  1, 0, 1, 3, 19, 'h018);
        add(1, 3, 21, 1, 4,  8,  0, 1, 1, 4,  7, 'h018);
        add(1, 3, 21, 1, 4,  9,  1, 0, 1, 3, 20, 'h018);
        add(1, 3, 22, 1, 4,  9,  0, 1, 1, 4,  8, 'h018);
        add(1, 3, 22, 1, 4, 10,  1, 0, 1, 3, 21, 'h018);
        add(0, 0,  0, 1, 4, 10,  0, 1, 1, 4,  9, 'h018);
        add(0, 0,  0, 0, 0,  0,  1, 0, 1, 3, 22, 'h018);
        add(0, 0,  0, 0, 0,  0,  1, 1, 1, 4, 10, 'h010);
        add(0, 0,  0, 0, 0,  0,  1, 1, 0, 0,  0, 'h000);
        // Single uncontested write r2 <- 42.
        add(1, 2, 42, 0, 0,  0,  1, 1, 0, 0,  0, 'h000);
        add(0, 0,  0, 0, 0,  0,  1, 1, 1, 2, 42, 'h004);
        add(0, 0,  0, 0, 0,  0,  1, 1, 0, 0,  0, 'h000);
        // Same-address ordering: ALU r5=1 then MEM r5=2, held behind MEM r9.
        add(1, 5,  1, 1, 9,  3,  1, 1, 0, 0,  0, 'h000);
        add(0, 0,  0, 1, 5,  2,  0, 1, 1, 9,  3, 'h220);
        add(0, 0,  0, 0, 0,  0,  1, 0, 1, 5,  1, 'h020);
        add(0, 0,  0, 0, 0,  0,  1, 1, 1, 5,  2, 'h020);
        // ALU-only write to leave last grant on ALU.
        add(1, 12, 7, 0, 0,  0,  1, 1, 0, 0,  0, 'h000);
        add(0, 0,  0, 0, 0,  0,  1, 1, 1, 12, 7, 'h1000);
        // Same edge, same address: ALU older wins although round-robin favours MEM.
        add(1, 11, 5, 1, 11, 6,  1, 1, 0, 0,  0, 'h000);
        add(0, 0,  0, 0, 0,  0,  1, 0, 1, 11, 5, 'h800);
        add(0, 0,  0, 0, 0,  0,  1, 1, 1, 11, 6, 'h800);
        // Register 0: accepted, never written, never pending.
        add(0, 0,  0, 1, 0, 15,  1, 1, 0, 0,  0, 'h000);
        add(0, 0,  0, 0, 0,  0,  1, 1, 0, 0,  0, 'h000);

        // Reset held with a request present.
        Reset_n = 1'b0;
        drive(1, 5'd2, 32'd9, 0, '0, '0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset regWrite", 32'(regWrite), 32'd0);
        check("reset alu_ready", 32'(alu_ready), 32'd0);
        check("reset mem_ready", 32'(mem_ready), 32'd0);
        check("reset pending", 32'(pending), 32'd0);
        check("reset writeData", writeData, 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        drive(0, '0, '0, 0, '0, '0);
        @(negedge Clk);
        check("release alu_ready", 32'(alu_ready), 32'd1);
        check("release mem_ready", 32'(mem_ready), 32'd1);

        foreach (vecs[i]) begin
            @(posedge Clk);
            #1;
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            @(negedge Clk);
            check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
            check($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
            check($sformatf("v%0d regWrite", i), 32'(regWrite), 32'(vecs[i].erw));
            check($sformatf("v%0d writeRegister", i), 32'(writeRegister), 32'(vecs[i].ewr));
            check($sformatf("v%0d writeData", i), writeData, vecs[i].ewd);
            check($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].epend));
        end

        @(posedge Clk);
        #1;
        drive(0, '0, '0, 0, '0, '0);
        repeat (2) @(negedge Clk);
        check("rf r0", rf[0], 32'd0);
        check("rf r2", rf[2], 32'd42);
        check("rf r3", rf[3], 32'd22);
        check("rf r4", rf[4], 32'd10);
        check("rf r5", rf[5], 32'd2);
        check("rf r9", rf[9], 32'd3);
        check("rf r11", rf[11], 32'd6);
        check("rf r12", rf[12], 32'd7);

        // Mid-operation reset with both slots full.
        @(posedge Clk);
        #1;
        drive(1, 5'd6, 32'hAA, 1, 5'd7, 32'hBB);
        @(negedge Clk);
        check("preload alu_ready", 32'(alu_ready), 32'd1);
        check("preload mem_ready", 32'(mem_ready), 32'd1);
        @(posedge Clk);
        #1;
        drive(0, '0, '0, 0, '0, '0);
        check("full pending", 32'(pending), 32'h0C0);
        check("full regWrite", 32'(regWrite), 32'd1);
        #1;
        Reset_n = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd8;
        alu_data  = 32'h55;
        #1;
        check("midreset regWrite", 32'(regWrite), 32'd0);
        check("midreset pending", 32'(pending), 32'd0);
        check("midreset alu_ready", 32'(alu_ready), 32'd0);
        check("midreset writeRegister", 32'(writeRegister), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        drive(0, '0, '0, 0, '0, '0);
        @(negedge Clk);
        check("post reset regWrite", 32'(regWrite), 32'd0);
        check("post reset pending", 32'(pending), 32'd0);
        check("post reset mem_ready", 32'(mem_ready), 32'd1);
        repeat (3) @(negedge Clk);
        check("rf r6 untouched", rf[6], 32'd0);
        check("rf r7 untouched", rf[7], 32'd0);
        check("rf r8 untouched", rf[8], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
